matrix_result_reader: RTL and testbench

MATRIX_RESULT_READER -- requirements
Module: matrix_result_reader

---
 rtl/matrix_result_reader.sv | 192 +++++++++++++++++++
 tb/tb_matrix_result_reader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_reader.sv
//=============================================================================
// Module   : matrix_result_reader
// Streams a ROWS x COLS result block out of data RAM in row-major order
// through a 2-entry output FIFO once every core has reported completion.
// Option   : define CHECKSUM_EN to build the running CHECKSUM accumulator.
// Revision : 1.0
//=============================================================================
`default_nettype none

module matrix_result_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_CORES  = 4
) (
  input  logic                  MAIN_CLOCK,
  input  logic                  RESET,
  input  logic [NUM_CORES-1:0]  PROCESS_DONE,
  input  logic [ADDR_WIDTH-1:0] RESULT_BASE,
  input  logic [7:0]            ROWS,
  input  logic [7:0]            COLS,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic                  RAM_RD_EN,
  input  logic [DATA_WIDTH-1:0] RAM_DATA_IN,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  OUT_LAST,
  output logic                  DUMP_DONE,
  output logic [DATA_WIDTH-1:0] CHECKSUM
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    rd_en_q;
  logic                    dv_q;
  logic                    done_q;
  logic [15:0]             total_q;
  logic [15:0]             issued_q;
  logic [15:0]             sent_q;
  logic [DATA_WIDTH-1:0]   mem_q [2];
  logic                    wr_ptr_q;
  logic                    rd_ptr_q;
  logic [1:0]              cnt_q;

  logic [1:0]              cnt_d;
  logic                    issue_d;
  logic [15:0]             total_in;
  logic                    all_done;
  logic                    xfer;
  logic                    last_elem;
  logic                    reads_left;

  assign total_in   = {8'd0, ROWS} * {8'd0, COLS};
  assign all_done   = &PROCESS_DONE;
  assign reads_left = (issued_q != total_q);
  assign last_elem  = (sent_q == (total_q - 16'd1));

  // Data returning from RAM is presented straight to the consumer when the
  // FIFO is empty, so the first element appears the cycle its data lands.
  assign OUT_VALID = (cnt_q != 2'd0) || dv_q;
  assign OUT_LAST  = OUT_VALID && last_elem;
  assign xfer      = OUT_VALID && OUT_READY;

  always_comb begin
    OUT_DATA = '0;
    if (cnt_q != 2'd0) begin
      OUT_DATA = mem_q[rd_ptr_q];
    end else if (dv_q) begin
      OUT_DATA = RAM_DATA_IN;
    end
  end

  // Credit check: entries held after this edge plus the read already in
  // flight must leave room for the read about to be issued.
  always_comb begin
    cnt_d   = cnt_q + {1'b0, dv_q} - {1'b0, xfer};
    issue_d = 1'b0;
    if ((state_q == S_READ) && reads_left && ((cnt_d + {1'b0, rd_en_q}) < 2'd2)) begin
      issue_d = 1'b1;
    end
  end

  always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rd_en_q  <= 1'b0;
      dv_q     <= 1'b0;
      done_q   <= 1'b0;
      total_q  <= '0;
      issued_q <= '0;
      sent_q   <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      rd_en_q <= 1'b0;
      dv_q    <= rd_en_q;
      cnt_q   <= cnt_d;

      if (dv_q && !(xfer && (cnt_q == 2'd0))) begin
        mem_q[wr_ptr_q] <= RAM_DATA_IN;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (xfer && (cnt_q != 2'd0)) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (xfer) begin
        sent_q <= sent_q + 16'd1;
      end

      case (state_q)
        S_IDLE: begin
          if (all_done) begin
            total_q  <= total_in;
            sent_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            if (total_in == 16'd0) begin
              issued_q <= '0;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              addr_q   <= RESULT_BASE;
              rd_en_q  <= 1'b1;
              issued_q <= 16'd1;
              state_q  <= S_READ;
            end
          end
        end
        S_READ: begin
          if (issue_d) begin
            addr_q   <= addr_q + 1'b1;
            rd_en_q  <= 1'b1;
            issued_q <= issued_q + 16'd1;
          end else if (!reads_left) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (xfer && last_elem) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (!all_done) begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign RAM_ADDR  = addr_q;
  assign RAM_RD_EN = rd_en_q;
  assign DUMP_DONE = done_q;

`ifdef CHECKSUM_EN
  logic [DATA_WIDTH-1:0] cks_q;

  always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
    if (RESET) begin
      cks_q <= '0;
    end else if ((state_q == S_IDLE) && all_done) begin
      cks_q <= '0;
    end else if (xfer) begin
      cks_q <= cks_q + OUT_DATA;
    end
  end

  assign CHECKSUM = cks_q;
`else
  assign CHECKSUM = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_matrix_result_reader.sv
//=============================================================================
// Module   : tb_matrix_result_reader
// Self-checking bench for matrix_result_reader: vector table, reset abort
// sequence and randomized dumps against a row-major reference model.
// Revision : 1.0
//=============================================================================
`default_nettype none

module tb_matrix_result_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  process_done;
  logic [15:0] result_base;
  logic [7:0]  rows_i;
  logic [7:0]  cols_i;
  logic [15:0] ram_addr;
  logic        ram_rd_en;
  logic [15:0] ram_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        dump_done;
  logic [15:0] checksum;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  matrix_result_reader #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(16),
    .NUM_CORES (4)
  ) dut (
    .MAIN_CLOCK  (clk),
    .RESET       (rst),
    .PROCESS_DONE(process_done),
    .RESULT_BASE (result_base),
    .ROWS        (rows_i),
    .COLS        (cols_i),
    .RAM_ADDR    (ram_addr),
    .RAM_RD_EN   (ram_rd_en),
    .RAM_DATA_IN (ram_data),
    .OUT_DATA    (out_data),
    .OUT_VALID   (out_valid),
    .OUT_READY   (out_ready),
    .OUT_LAST    (out_last),
    .DUMP_DONE   (dump_done),
    .CHECKSUM    (checksum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle-latency data RAM
  logic [15:0] ram [0:65535];
  initial ram_data = '0;
  always @(posedge clk) if (ram_rd_en) ram_data <= ram[ram_addr];

  // Monitor state
  int          n_rd, n_out, first_rd, first_valid, first_done, last_xfer, max_out, hold_err;
  logic [15:0] last_addr;
  bit          have_addr, stalled_prev;
  logic [15:0] prev_data;
  logic        prev_last;
  logic [15:0] done_cks;
  logic [15:0] rd_q[$];
  logic [15:0] od_q[$];
  logic        ol_q[$];

  typedef struct {
    logic [15:0] base;
    logic [7:0]  rows;
    logic [7:0]  cols;
    int          mode;      // 0: ready high, 1: ready 1,0,0 pattern, 2: random
    int          exp_n;
    logic [15:0] exp_last_addr;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    n_rd = 0; n_out = 0; first_rd = -1; first_valid = -1; first_done = -1;
    last_xfer = -1; max_out = 0; hold_err = 0; have_addr = 0; stalled_prev = 0;
    done_cks = '0;
    rd_q.delete(); od_q.delete(); ol_q.delete();
  endtask

  function automatic logic ready_of(input int mode, input int ph);
    case (mode)
      0:       return 1'b1;
      1:       return (ph % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  always @(negedge clk) begin
    if (ram_rd_en) begin
      rd_q.push_back(ram_addr);
      n_rd++;
      if (first_rd < 0) first_rd = cyc;
      last_addr = ram_addr;
      have_addr = 1;
    end else if (have_addr && (ram_addr !== last_addr)) begin
      hold_err++;
    end
    if ((n_rd - n_out) > max_out) max_out = n_rd - n_out;
    if (out_valid && (first_valid < 0)) first_valid = cyc;
    if (stalled_prev) begin
      checks++;
      if (!out_valid || (out_data !== prev_data) || (out_last !== prev_last)) begin
        errors++;
        $display("FAIL stall_hold cycle %0d: valid=%0b data=0x%0h last=%0b, expected valid=1 data=0x%0h last=%0b",
                 cyc, out_valid, out_data, out_last, prev_data, prev_last);
      end
    end
    stalled_prev = out_valid && !out_ready;
    prev_data    = out_data;
    prev_last    = out_last;
    if (out_valid && out_ready) begin
      od_q.push_back(out_data);
      ol_q.push_back(out_last);
      n_out++;
      last_xfer = cyc;
    end
    if (dump_done && (first_done < 0)) begin
      first_done = cyc;
      done_cks   = checksum;
    end
  end

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " rd_en"},     32'(ram_rd_en), 32'd0);
    chk({tag, " ram_addr"},  32'(ram_addr),  32'd0);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " out_data"},  32'(out_data),  32'd0);
    chk({tag, " out_last"},  32'(out_last),  32'd0);
    chk({tag, " dump_done"}, 32'(dump_done), 32'd0);
    chk({tag, " checksum"},  32'(checksum),  32'd0);
  endtask

  // Full dump: trigger, run to DONE, confirm no retrigger, re-arm to IDLE.
  task automatic run_dump(input logic [15:0] base, input logic [7:0] rows, input logic [7:0] cols,
                          input int mode, input int exp_n, input logic [15:0] exp_last,
                          input bit from_reset, input string tag);
    int          total, t0, ph, waited;
    logic [15:0] a, sum, exp_cks;
    total = int'(rows) * int'(cols);
    @(posedge clk); #1;
    clear_mon();
    result_base  = base;
    rows_i       = rows;
    cols_i       = cols;
    if (from_reset) rst = 1'b0;
    process_done = 4'b1111;
    out_ready    = ready_of(mode, 0);
    t0 = cyc; ph = 1; waited = 0;
    while ((first_done < 0) && (waited < 4000)) begin
      @(posedge clk); #1;
      waited++;
      if (n_out < total) begin
        result_base  = 16'($urandom);
        rows_i       = 8'($urandom);
        cols_i       = 8'($urandom);
        process_done = 4'($urandom);
      end else begin
        process_done = 4'b1111;
      end
      out_ready = ready_of(mode, ph);
      ph++;
    end
    chk({tag, " done_reached"}, 32'(first_done >= 0), 32'd1);
    repeat (5) begin @(posedge clk); #1; end
    chk({tag, " done_held"}, 32'(dump_done), 32'd1);
    chk({tag, " reads"},     32'(n_rd),  32'(total));
    chk({tag, " transfers"}, 32'(n_out), 32'(exp_n));

    sum = '0;
    for (int k = 0; k < total; k++) begin
      a = base + 16'(k);
      sum = sum + ram[a];
      if (k < n_out) begin
        chk($sformatf("%s data[%0d]", tag, k), 32'(od_q[k]), 32'(ram[a]));
        chk($sformatf("%s last[%0d]", tag, k), 32'(ol_q[k]), 32'(k == total - 1));
      end
      if (k < n_rd) chk($sformatf("%s addr[%0d]", tag, k), 32'(rd_q[k]), 32'(a));
    end

    if (total > 0) begin
      chk({tag, " first_rd_cycle"},    32'(first_rd),    32'(t0 + 1));
      chk({tag, " first_valid_cycle"}, 32'(first_valid), 32'(t0 + 2));
      chk({tag, " done_after_last"},   32'(first_done),  32'(last_xfer + 1));
      if (n_rd > 0) chk({tag, " last_addr"}, 32'(rd_q[n_rd-1]), 32'(exp_last));
      if (mode == 0) chk({tag, " back_to_back"}, 32'(last_xfer), 32'(first_valid + total - 1));
    end else begin
      chk({tag, " no_reads"},      32'(first_rd),    32'hFFFF_FFFF);
      chk({tag, " no_valid"},      32'(first_valid), 32'hFFFF_FFFF);
      chk({tag, " direct_done"},   32'(first_done),  32'(t0 + 1));
    end
    chk({tag, " outstanding<=2"}, 32'(max_out <= 2), 32'd1);
    chk({tag, " addr_hold"},      32'(hold_err), 32'd0);
`ifdef CHECKSUM_EN
    exp_cks = sum;
`else
    exp_cks = '0;
`endif
    chk({tag, " checksum"},      32'(done_cks), 32'(exp_cks));
    chk({tag, " checksum_held"}, 32'(checksum), 32'(exp_cks));

    process_done = 4'b0000;
    @(posedge clk); #1;
    chk({tag, " rearm_idle"}, 32'(dump_done), 32'd0);
  endtask

  initial begin
    int waited;
    rst = 1'b1; process_done = '0; out_ready = 1'b0;
    result_base = '0; rows_i = '0; cols_i = '0;
    for (int i = 0; i < 65536; i++) ram[i] = 16'($urandom);
    ram[16'h0100] = 16'd1; ram[16'h0101] = 16'd2;
    ram[16'h0102] = 16'd3; ram[16'h0103] = 16'd4;
    clear_mon();

    vecs[0] = '{16'h0100,  8'd2,  8'd2, 0,   4, 16'h0103};
    vecs[1] = '{16'h0100,  8'd2,  8'd2, 1,   4, 16'h0103};
    vecs[2] = '{16'h0040,  8'd0,  8'd5, 0,   0, 16'h0000};
    vecs[3] = '{16'hFFFE,  8'd1,  8'd4, 0,   4, 16'h0001};
    vecs[4] = '{16'h2000,  8'd3,  8'd3, 2,   9, 16'h2008};
    vecs[5] = '{16'h0005,  8'd1,  8'd1, 1,   1, 16'h0005};
    vecs[6] = '{16'h0300,  8'd5,  8'd0, 0,   0, 16'h0000};
    vecs[7] = '{16'h8000, 8'd16, 8'd16, 2, 256, 16'h80FF};
    vecs[8] = '{16'hFFF0,  8'd4,  8'd8, 1,  32, 16'h000F};

    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b0;

    // Not every core finished: must stay idle
    @(posedge clk); #1;
    clear_mon();
    process_done = 4'b0111;
    repeat (10) begin @(posedge clk); #1; end
    chk("partial_done no_reads", 32'(n_rd), 32'd0);
    chk("partial_done no_valid", 32'(first_valid), 32'hFFFF_FFFF);
    chk("partial_done idle",     32'(dump_done), 32'd0);
    process_done = 4'b0000;

    for (int i = 0; i < 9; i++)
      run_dump(vecs[i].base, vecs[i].rows, vecs[i].cols, vecs[i].mode,
               vecs[i].exp_n, vecs[i].exp_last_addr, 1'b0, $sformatf("vec%0d", i));

    // Reset two elements into a 3x3 dump, then restart with cores still done
    @(posedge clk); #1;
    clear_mon();
    result_base = 16'h3000; rows_i = 8'd3; cols_i = 8'd3;
    out_ready = 1'b1; process_done = 4'b1111;
    waited = 0;
    while ((n_out < 2) && (waited < 100)) begin @(posedge clk); #1; waited++; end
    chk("abort two_sent", 32'(n_out), 32'd2);
    rst = 1'b1;
    #1;
    chk_outputs_zero("abort");
    @(posedge clk); #1;
    chk_outputs_zero("abort_held");
    run_dump(16'h3000, 8'd3, 8'd3, 0, 9, 16'h3008, 1'b1, "after_reset");

    for (int r = 0; r < 10; r++) begin
      logic [15:0] b;
      logic [7:0]  rr, cc;
      int          m, n;
      b  = 16'($urandom);
      rr = 8'($urandom_range(0, 6));
      cc = 8'($urandom_range(0, 6));
      m  = int'($urandom_range(0, 2));
      n  = int'(rr) * int'(cc);
      run_dump(b, rr, cc, m, n, b + 16'(n) - 16'd1, 1'b0, $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
